// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cpu_pkg                                                       |
// | Brief  : Shared state encoding for the multicycle stage sequencer and  |
// |          opcode class constants used by the instruction decoder.       |
// | Rev    : 1.0  initial release                                          |
// +----------------------------------------------------------------------+
package cpu_pkg;

  // One-hot state encoding, one bit per sequencer stage
  localparam logic [5:0] c_ST_IDLE      = 6'b000001;
  localparam logic [5:0] c_ST_FETCH     = 6'b000010;
  localparam logic [5:0] c_ST_DECODE    = 6'b000100;
  localparam logic [5:0] c_ST_EXECUTE   = 6'b001000;
  localparam logic [5:0] c_ST_MEMORY    = 6'b010000;
  localparam logic [5:0] c_ST_WRITEBACK = 6'b100000;

  // Enumerated view of the same encoding for debug and decode code
  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_FETCH     = 6'b000010,
    ST_DECODE    = 6'b000100,
    ST_EXECUTE   = 6'b001000,
    ST_MEMORY    = 6'b010000,
    ST_WRITEBACK = 6'b100000
  } state_e;

  // Instruction class fields shared with decode
  localparam logic [2:0] c_OPC_BRANCH  = 3'b101;  // bits [27:25] for B/BL
  localparam logic [1:0] c_OPC_LDRSTR  = 2'b01;   // bits [27:26] for LDR/STR
  localparam int unsigned c_LINK_BIT   = 24;      // L bit: BL writes LR
  localparam int unsigned c_LOAD_BIT   = 20;      // L bit: LDR vs STR

endpackage
`default_nettype wire

// File: rtl/seq_mem_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seq_mem_timer                                                 |
// | Brief  : Counts MEMORY-stage cycles without acknowledge and flags the  |
// |          cycle in which the wait limit is reached.                     |
// | Rev    : 1.0  initial release                                          |
// +----------------------------------------------------------------------+
module seq_mem_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic nreset,
  input  logic clr,
  input  logic en,
  input  logic ack,
  output logic expired
);

  localparam int c_CNT_W = $clog2(MEM_TIMEOUT + 1);
  // Count value held during the last permitted wait cycle
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_SAT  = c_CNT_W'(MEM_TIMEOUT);

  logic [c_CNT_W-1:0] r_count;

  // Count unacknowledged wait cycles, saturating, cleared outside MEMORY
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !ack && (r_count != c_SAT)) begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

  // Expiry is seen in the final wait cycle so the FSM leaves right after it
  assign expired = en && !ack && (r_count >= c_LAST);

endmodule
`default_nettype wire

// File: rtl/cpu_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cpu_stage_sequencer                                           |
// | Brief  : Multicycle control FSM stepping FETCH/DECODE/EXECUTE/MEMORY/  |
// |          WRITEBACK, with condition-gated writes and retire counter.    |
// | Rev    : 1.0  initial release                                          |
// +----------------------------------------------------------------------+
module cpu_stage_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             run,
  input  logic             halt,
  input  logic             imem_ready,
  input  logic             cond_pass,
  input  logic             is_mem,
  input  logic             is_load,
  input  logic             is_branch,
  input  logic             wb_req,
  input  logic             s_bit,
  input  logic             mem_ack,
  output logic             if_en,
  output logic             rf_en,
  output logic             ex_en,
  output logic             mem_req,
  output logic             mem_rnw,
  output logic             reg_we,
  output logic             cpsr_we,
  output logic             pc_en,
  output logic             pc_sel_br,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] retired_cnt
);

  logic [5:0]       r_state;
  logic             r_cp;
  logic             r_isMem;
  logic             r_isLoad;
  logic             r_isBranch;
  logic             r_wbReq;
  logic             r_sBit;
  logic             r_fault;
  logic [CNT_W-1:0] r_retiredCnt;

  logic w_stIdle;
  logic w_stFetch;
  logic w_stDecode;
  logic w_stExecute;
  logic w_stMemory;
  logic w_stWriteback;
  logic w_memExpired;

  assign w_stIdle      = (r_state == c_ST_IDLE);
  assign w_stFetch     = (r_state == c_ST_FETCH);
  assign w_stDecode    = (r_state == c_ST_DECODE);
  assign w_stExecute   = (r_state == c_ST_EXECUTE);
  assign w_stMemory    = (r_state == c_ST_MEMORY);
  assign w_stWriteback = (r_state == c_ST_WRITEBACK);

  seq_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_memTimer (
    .clk    (clk),
    .nreset (nreset),
    .clr    (!w_stMemory),
    .en     (w_stMemory),
    .ack    (mem_ack),
    .expired(w_memExpired)
  );

  // Stage sequencing, per-instruction attribute capture, fault and retire count
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= c_ST_IDLE;
      r_cp         <= 1'b0;
      r_isMem      <= 1'b0;
      r_isLoad     <= 1'b0;
      r_isBranch   <= 1'b0;
      r_wbReq      <= 1'b0;
      r_sBit       <= 1'b0;
      r_fault      <= 1'b0;
      r_retiredCnt <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          // A memory fault parks the sequencer here until reset
          if (run && !r_fault) r_state <= c_ST_FETCH;
        end
        c_ST_FETCH: begin
          if (imem_ready) r_state <= c_ST_DECODE;
        end
        c_ST_DECODE: begin
          r_state <= c_ST_EXECUTE;
        end
        c_ST_EXECUTE: begin
          r_cp       <= cond_pass;
          r_isMem    <= is_mem;
          r_isLoad   <= is_load;
          r_isBranch <= is_branch;
          r_wbReq    <= wb_req;
          r_sBit     <= s_bit;
          // A failed condition never touches data memory
          r_state    <= (cond_pass && is_mem) ? c_ST_MEMORY : c_ST_WRITEBACK;
        end
        c_ST_MEMORY: begin
          // Acknowledge takes priority over a simultaneous timeout
          if (mem_ack) begin
            r_state <= c_ST_WRITEBACK;
          end else if (w_memExpired) begin
            r_fault <= 1'b1;
            r_state <= c_ST_IDLE;
          end
        end
        c_ST_WRITEBACK: begin
          r_retiredCnt <= r_retiredCnt + CNT_W'(r_cp);
          r_state      <= halt ? c_ST_IDLE : c_ST_FETCH;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from state and captured attributes
  assign if_en       = w_stFetch && imem_ready;
  assign rf_en       = w_stDecode;
  assign ex_en       = w_stExecute;
  assign mem_req     = w_stMemory && r_isMem;
  assign mem_rnw     = w_stMemory && r_isLoad;
  assign pc_en       = w_stWriteback;
  assign reg_we      = w_stWriteback && r_cp && r_wbReq;
  assign cpsr_we     = w_stWriteback && r_cp && r_sBit;
  assign pc_sel_br   = w_stWriteback && r_cp && r_isBranch;
  assign busy        = !w_stIdle;
  assign fault       = r_fault;
  assign retired_cnt = r_retiredCnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_cpu_stage_sequencer                                        |
// | Brief  : Directed self-checking bench for cpu_stage_sequencer.         |
// | Rev    : 1.0  initial release                                          |
// +----------------------------------------------------------------------+
module tb_cpu_stage_sequencer;

  localparam int c_TO  = 4;
  localparam int c_CW  = 4;

  // Output vector bit positions
  localparam logic [10:0] c_IF   = 11'b10000000000;
  localparam logic [10:0] c_RF   = 11'b01000000000;
  localparam logic [10:0] c_EX   = 11'b00100000000;
  localparam logic [10:0] c_MREQ = 11'b00010000000;
  localparam logic [10:0] c_MRNW = 11'b00001000000;
  localparam logic [10:0] c_RWE  = 11'b00000100000;
  localparam logic [10:0] c_CWE  = 11'b00000010000;
  localparam logic [10:0] c_PC   = 11'b00000001000;
  localparam logic [10:0] c_BR   = 11'b00000000100;
  localparam logic [10:0] c_BUSY = 11'b00000000010;
  localparam logic [10:0] c_FLT  = 11'b00000000001;
  localparam logic [10:0] c_NONE = 11'b00000000000;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic run = 1'b0, halt = 1'b0, imem_ready = 1'b0, cond_pass = 1'b0;
  logic is_mem = 1'b0, is_load = 1'b0, is_branch = 1'b0, wb_req = 1'b0;
  logic s_bit = 1'b0, mem_ack = 1'b0;
  logic if_en, rf_en, ex_en, mem_req, mem_rnw, reg_we, cpsr_we;
  logic pc_en, pc_sel_br, busy, fault;
  logic [c_CW-1:0] retired_cnt;

  int errors = 0;
  int checks = 0;

  cpu_stage_sequencer #(
    .MEM_TIMEOUT(c_TO),
    .CNT_W      (c_CW)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .run        (run),
    .halt       (halt),
    .imem_ready (imem_ready),
    .cond_pass  (cond_pass),
    .is_mem     (is_mem),
    .is_load    (is_load),
    .is_branch  (is_branch),
    .wb_req     (wb_req),
    .s_bit      (s_bit),
    .mem_ack    (mem_ack),
    .if_en      (if_en),
    .rf_en      (rf_en),
    .ex_en      (ex_en),
    .mem_req    (mem_req),
    .mem_rnw    (mem_rnw),
    .reg_we     (reg_we),
    .cpsr_we    (cpsr_we),
    .pc_en      (pc_en),
    .pc_sel_br  (pc_sel_br),
    .busy       (busy),
    .fault      (fault),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chkOut(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    #1;
    obs = {if_en, rf_en, ex_en, mem_req, mem_rnw, reg_we, cpsr_we,
           pc_en, pc_sel_br, busy, fault};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkCnt(input string tag, input logic [c_CW-1:0] exp);
    #1;
    checks++;
    assert (retired_cnt === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, retired_cnt, exp);
    end
  endtask

  task automatic setInstr(input logic cp, input logic mem, input logic ld,
                          input logic br, input logic wb, input logic s);
    cond_pass = cp; is_mem = mem; is_load = ld;
    is_branch = br; wb_req = wb; s_bit = s;
  endtask

  initial begin
    // Reset state
    tick();
    chkOut("reset_outputs", c_NONE);
    chkCnt("reset_cnt", 4'd0);
    nreset = 1'b1;

    // ADD, condition passes
    setInstr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    imem_ready = 1'b1; run = 1'b1;
    chkOut("add_idle", c_NONE);
    tick(); run = 1'b0;
    chkOut("add_fetch", c_IF | c_BUSY);
    tick(); chkOut("add_decode", c_RF | c_BUSY);
    tick(); chkOut("add_execute", c_EX | c_BUSY);
    tick(); chkOut("add_wb", c_PC | c_RWE | c_BUSY);
    chkCnt("add_cnt_before", 4'd0);
    halt = 1'b1;
    tick(); chkOut("add_idle_after", c_NONE);
    chkCnt("add_cnt_after", 4'd1);

    // Failed condition on a load, with a stalled fetch first
    halt = 1'b0; imem_ready = 1'b0; run = 1'b1;
    setInstr(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); run = 1'b0;
    chkOut("ncp_fetch_wait1", c_BUSY);
    tick(); chkOut("ncp_fetch_wait2", c_BUSY);
    imem_ready = 1'b1;
    chkOut("ncp_fetch_ready", c_IF | c_BUSY);
    tick(); chkOut("ncp_decode", c_RF | c_BUSY);
    tick(); chkOut("ncp_execute", c_EX | c_BUSY);
    tick(); chkOut("ncp_wb", c_PC | c_BUSY);
    halt = 1'b1;
    tick(); chkOut("ncp_idle", c_NONE);
    chkCnt("ncp_cnt", 4'd1);

    // LDR acknowledged in its third MEMORY cycle, with flag update
    halt = 1'b0; run = 1'b1;
    setInstr(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); run = 1'b0;
    tick(); tick();
    chkOut("ldr_execute", c_EX | c_BUSY);
    tick(); chkOut("ldr_mem1", c_MREQ | c_MRNW | c_BUSY);
    tick(); chkOut("ldr_mem2", c_MREQ | c_MRNW | c_BUSY);
    tick(); mem_ack = 1'b1;
    chkOut("ldr_mem3", c_MREQ | c_MRNW | c_BUSY);
    tick(); mem_ack = 1'b0;
    chkOut("ldr_wb", c_PC | c_RWE | c_CWE | c_BUSY);
    halt = 1'b1;
    tick(); chkOut("ldr_idle", c_NONE);
    chkCnt("ldr_cnt", 4'd2);

    // STR acknowledged in the same cycle the wait limit is reached
    halt = 1'b0; run = 1'b1;
    setInstr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); run = 1'b0;
    tick(); tick();
    for (int i = 0; i < c_TO; i++) begin
      tick();
      if (i == c_TO - 1) mem_ack = 1'b1;
      chkOut("stra_mem", c_MREQ | c_BUSY);
    end
    tick(); mem_ack = 1'b0;
    chkOut("stra_wb", c_PC | c_BUSY);
    halt = 1'b1;
    tick(); chkOut("stra_idle", c_NONE);
    chkCnt("stra_cnt", 4'd3);

    // STR never acknowledged: timeout, sticky fault
    halt = 1'b0; run = 1'b1;
    tick();
    tick(); tick();
    for (int i = 0; i < c_TO; i++) begin
      tick();
      chkOut("strt_mem", c_MREQ | c_BUSY);
    end
    tick(); chkOut("strt_fault_idle", c_FLT);
    tick(); chkOut("strt_run_ignored", c_FLT);
    chkCnt("strt_cnt", 4'd3);
    run = 1'b0;
    nreset = 1'b0;
    chkOut("strt_fault_cleared", c_NONE);
    tick(); nreset = 1'b1;

    // BL taken with halt raised during DECODE
    run = 1'b1;
    setInstr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); run = 1'b0;
    tick(); halt = 1'b1;
    chkOut("bl_decode", c_RF | c_BUSY);
    tick(); tick();
    chkOut("bl_wb", c_PC | c_RWE | c_BR | c_BUSY);
    tick(); chkOut("bl_idle", c_NONE);
    chkCnt("bl_cnt", 4'd1);

    // Reset pulse while a load request is outstanding
    halt = 1'b0; run = 1'b1;
    setInstr(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); run = 1'b0;
    tick(); tick(); tick();
    chkOut("rst_mem_pending", c_MREQ | c_MRNW | c_BUSY);
    nreset = 1'b0;
    chkOut("rst_mem_dropped", c_NONE);
    chkCnt("rst_cnt", 4'd0);
    tick(); nreset = 1'b1;

    // Seventeen back-to-back ADDs wrap the 4-bit counter to 1
    setInstr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 0) chkOut("wrap_first_fetch", c_IF | c_BUSY);
      tick(); tick(); tick();
      if (i == 16) begin
        chkCnt("wrap_cnt_16", 4'd0);
        halt = 1'b1;
      end
    end
    chkOut("wrap_last_wb", c_PC | c_RWE | c_BUSY);
    tick(); run = 1'b0;
    chkOut("wrap_idle", c_NONE);
    chkCnt("wrap_cnt_17", 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
